// File: rtl/mmio_io_hub_pkg.sv
// mmio_io_hub_pkg: register map offsets, STATUS/CTRL bit positions and default hub base address
//   Used by mmio_io_hub and io_key_fifo; no ports.
package mmio_io_hub_pkg;
    localparam logic [31:0] HUB_BASE_DEFAULT = 32'hFFFF_FC00;
    localparam logic [7:0]  OFF_STATUS = 8'h00;
    localparam logic [7:0]  OFF_KEY    = 8'h04;
    localparam logic [7:0]  OFF_CTRL   = 8'h08;
    localparam logic [7:0]  OFF_IN     = 8'h10;
    localparam logic [7:0]  OFF_OUT    = 8'h20;
    localparam int ST_CONF     = 0;
    localparam int ST_NONEMPTY = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_COUNT    = 8;
    localparam int CTRL_CLR_CONF = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_FLUSH    = 2;
    function automatic logic [7:0] port_off(input logic [7:0] base, input int i);
        return base + 8'(4 * i);
    endfunction
endpackage

// File: rtl/io_key_fifo.sv
// io_key_fifo: key-code FIFO with push, pop, flush, head, count and full/empty flags
//   clk, rstn      clock, async active-low reset
//   push, din      enqueue din (dropped when full unless popping in the same cycle)
//   pop            dequeue head (ignored when empty)
//   flush          empties the FIFO, overrides push and pop
//   head           oldest entry (meaningless when empty)
//   count          occupancy, 0..DEPTH
//   full, empty    occupancy flags
module io_key_fifo
    import mmio_io_hub_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign head    = mem[rptr];
    assign do_pop  = pop & ~empty;
    // a pop frees the slot the simultaneous push needs
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end
endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub with input ports, output registers, key FIFO and confirm flag
//   clk, rstn          clock, async active-low reset
//   io_read, io_write  core I/O load / store this cycle
//   addr, wdata        byte address and store data
//   rdata              combinational load data (0 when not reading or on a miss)
//   in_data            N_IN input ports, IN_W bits each
//   conf_btn           debounced confirm button level
//   key_valid, key_code new key pulse and code
//   out_data           N_OUT output registers, OUT_W bits each
//   out_strobe         per-port pulse the cycle after a write
//   key_ovf            sticky FIFO overflow flag
module mmio_io_hub
    import mmio_io_hub_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = HUB_BASE_DEFAULT,
    parameter int          N_IN       = 2,
    parameter int          IN_W       = 16,
    parameter int          N_OUT      = 2,
    parameter int          OUT_W      = 32,
    parameter int          KEY_W      = 4,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   io_read,
    input  logic                   io_write,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    input  logic [N_IN*IN_W-1:0]   in_data,
    input  logic                   conf_btn,
    input  logic                   key_valid,
    input  logic [KEY_W-1:0]       key_code,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic [N_OUT-1:0]       out_strobe,
    output logic                   key_ovf
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [7:0]       off;
    logic             hit, rd, wr, key_rd, ctrl_wr, flush, ovf_set;
    logic             conf_prev, conf_pending;
    logic [KEY_W-1:0] head;
    logic [CW-1:0]    count;
    logic             full, empty;
    logic [N_OUT-1:0] out_wr;
    logic [31:0]      status;
    assign off     = addr[7:0];
    assign hit     = addr[31:8] == BASE_ADDR[31:8];
    assign rd      = io_read & hit;
    assign wr      = io_write & hit;
    // a read that coincides with a write must not pop
    assign key_rd  = rd & ~io_write & (off == OFF_KEY);
    assign ctrl_wr = wr & (off == OFF_CTRL);
    assign flush   = ctrl_wr & wdata[CTRL_FLUSH];
    assign ovf_set = key_valid & full & ~key_rd & ~flush;
    io_key_fifo #(.W(KEY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (key_valid),
        .pop  (key_rd),
        .flush(flush),
        .din  (key_code),
        .head (head),
        .count(count),
        .full (full),
        .empty(empty)
    );
    genvar i;
    generate
        for (i = 0; i < N_OUT; i++) begin : g_wr
            assign out_wr[i] = wr & (off == port_off(OFF_OUT, i));
        end
    endgenerate
    always_comb begin
        status                  = '0;
        status[ST_CONF]         = conf_pending;
        status[ST_NONEMPTY]     = ~empty;
        status[ST_FULL]         = full;
        status[ST_OVF]          = key_ovf;
        status[ST_COUNT +: CW]  = count;
    end
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (off == OFF_STATUS) rdata = status;
            if (off == OFF_KEY && !empty) rdata = 32'(head);
            for (int j = 0; j < N_IN; j++)
                if (off == port_off(OFF_IN, j)) rdata = 32'(in_data[j*IN_W +: IN_W]);
            for (int j = 0; j < N_OUT; j++)
                if (off == port_off(OFF_OUT, j)) rdata = 32'(out_data[j*OUT_W +: OUT_W]);
        end
    end
    // set beats clear for both sticky flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conf_prev    <= 1'b0;
            conf_pending <= 1'b0;
            key_ovf      <= 1'b0;
            out_strobe   <= '0;
            out_data     <= '0;
        end else begin
            conf_prev    <= conf_btn;
            conf_pending <= (conf_btn & ~conf_prev) | (conf_pending & ~(ctrl_wr & wdata[CTRL_CLR_CONF]));
            key_ovf      <= ovf_set | (key_ovf & ~(ctrl_wr & wdata[CTRL_CLR_OVF]));
            out_strobe   <= out_wr;
            for (int j = 0; j < N_OUT; j++)
                if (out_wr[j]) out_data[j*OUT_W +: OUT_W] <= wdata[OUT_W-1:0];
        end
    end
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed and randomized self-checking bench for mmio_io_hub against a queue-based model
module tb_mmio_io_hub;
    localparam int DEPTH = 8;
    logic        clk = 0, rstn = 0;
    logic        io_read = 0, io_write = 0, conf_btn = 0, key_valid = 0;
    logic [31:0] addr = 0, wdata = 0, rdata;
    logic [31:0] in_data = 0;
    logic [3:0]  key_code = 0;
    logic [63:0] out_data;
    logic [1:0]  out_strobe;
    logic        key_ovf;
    int          n_cmp = 0, n_bad = 0;
    logic [3:0]  q[$];
    logic        m_conf = 0, m_prev = 0, m_ovf = 0;
    logic [31:0] m_out[2] = '{0, 0};
    logic [1:0]  m_strobe = 0;
    bit          mvalid = 0;

    always #5 clk = ~clk;

    mmio_io_hub #(
        .BASE_ADDR(32'hFFFF_FC00), .N_IN(2), .IN_W(16), .N_OUT(2),
        .OUT_W(32), .KEY_W(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .in_data(in_data),
        .conf_btn(conf_btn), .key_valid(key_valid), .key_code(key_code),
        .out_data(out_data), .out_strobe(out_strobe), .key_ovf(key_ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rdata();
        if (!io_read || addr[31:8] != 24'hFFFFFC) return 32'h0;
        case (addr[7:0])
            8'h00: return {17'b0, 7'(q.size()), 4'b0, m_ovf, q.size() == DEPTH, q.size() != 0, m_conf};
            8'h04: return q.size() != 0 ? 32'(q[0]) : 32'h0;
            8'h10: return {16'h0, in_data[15:0]};
            8'h14: return {16'h0, in_data[31:16]};
            8'h20: return m_out[0];
            8'h24: return m_out[1];
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin : model
        bit win, rdk, ctl, cedge, ovf_set, wo;
        if (!rstn) begin
            q.delete();
            m_conf = 0; m_prev = 0; m_ovf = 0; m_out = '{0, 0}; m_strobe = 0; mvalid = 1;
            chk("rst_out_data", out_data, 64'h0);
            chk("rst_strobe", {62'h0, out_strobe}, 64'h0);
            chk("rst_ovf", {63'h0, key_ovf}, 64'h0);
        end else if (mvalid) begin
            chk("rdata", {32'h0, rdata}, {32'h0, m_rdata()});
            chk("out_data", out_data, {m_out[1], m_out[0]});
            chk("out_strobe", {62'h0, out_strobe}, {62'h0, m_strobe});
            chk("key_ovf", {63'h0, key_ovf}, {63'h0, m_ovf});
            win     = addr[31:8] == 24'hFFFFFC;
            rdk     = io_read && !io_write && win && addr[7:0] == 8'h04;
            ctl     = io_write && win && addr[7:0] == 8'h08;
            cedge   = conf_btn && !m_prev;
            ovf_set = 0;
            m_conf  = cedge || (m_conf && !(ctl && wdata[0]));
            m_prev  = conf_btn;
            if (ctl && wdata[2]) q.delete();
            else begin
                if (rdk && q.size() > 0) void'(q.pop_front());
                if (key_valid) begin
                    if (q.size() < DEPTH) q.push_back(key_code);
                    else ovf_set = 1;
                end
            end
            m_ovf = ovf_set || (m_ovf && !(ctl && wdata[1]));
            for (int i = 0; i < 2; i++) begin
                wo = io_write && win && addr[7:0] == 8'(8'h20 + 4 * i);
                m_strobe[i] = wo;
                if (wo) m_out[i] = wdata;
            end
        end
    end

    task automatic idle();
        io_read = 0; io_write = 0; key_valid = 0; addr = 0; wdata = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a; io_read = 1;
        #3;
        chk(nm, {32'h0, rdata}, {32'h0, exp});
        cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; io_write = 1;
        cyc();
    endtask

    task automatic push(input logic [3:0] k);
        key_valid = 1; key_code = k;
        cyc();
    endtask

    logic [7:0] offs[12] = '{8'h00, 8'h04, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h28, 8'h0C, 8'h02};

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        rd(32'hFFFF_FC00, 32'h0, "status_reset");
        rd(32'hFFFF_FC20, 32'h0, "out0_reset");
        rd(32'hFFFF_FC24, 32'h0, "out1_reset");
        rd(32'hFFFF_FC04, 32'h0, "key_reset");
        wr(32'hFFFF_FC20, 32'h1122_3344);
        push(4'd1); push(4'd2); push(4'd3);
        rd(32'hFFFF_FC00, 32'h0000_0302, "status_3keys");
        rstn = 0;
        #3 chk("midrst_out_data", out_data, 64'h0);
        @(posedge clk); #1 rstn = 1;
        rd(32'hFFFF_FC00, 32'h0, "status_after_midrst");
        in_data = {16'hA5C3, 16'h1234};
        rd(32'hFFFF_FC14, 32'h0000_A5C3, "in1");
        rd(32'hFFFF_FC10, 32'h0000_1234, "in0");
        rd(32'hFFFF_FC18, 32'h0, "in2_unmapped");
        rd(32'hFFFF_FD14, 32'h0, "base_miss");
        for (int k = 1; k <= 8; k++) push(4'(k));
        push(4'd9);
        rd(32'hFFFF_FC00, 32'h0000_080E, "status_full_ovf");
        for (int k = 1; k <= 8; k++) rd(32'hFFFF_FC04, 32'(k), "key_pop_order");
        rd(32'hFFFF_FC04, 32'h0, "key_pop_empty");
        rd(32'hFFFF_FC00, 32'h0000_0008, "status_ovf_only");
        wr(32'hFFFF_FC08, 32'h2);
        rd(32'hFFFF_FC00, 32'h0, "status_ovf_clr");
        for (int k = 8; k <= 15; k++) push(4'(k));
        key_valid = 1; key_code = 4'd3;
        rd(32'hFFFF_FC04, 32'h8, "key_full_push_pop");
        rd(32'hFFFF_FC00, 32'h0000_0806, "status_full_push_pop");
        chk("ovf_full_push_pop", {63'h0, key_ovf}, 64'h0);
        wr(32'hFFFF_FC08, 32'h4);
        rd(32'hFFFF_FC00, 32'h0, "status_flush");
        key_valid = 1; key_code = 4'd5;
        rd(32'hFFFF_FC04, 32'h0, "key_empty_push_pop");
        rd(32'hFFFF_FC04, 32'h5, "key_after_empty_pp");
        conf_btn = 1;
        cyc();
        rd(32'hFFFF_FC00, 32'h1, "conf_set");
        cyc();
        rd(32'hFFFF_FC00, 32'h1, "conf_hold");
        conf_btn = 0;
        cyc();
        conf_btn = 1;
        wr(32'hFFFF_FC08, 32'h1);
        rd(32'hFFFF_FC00, 32'h1, "conf_set_wins");
        wr(32'hFFFF_FC08, 32'h1);
        rd(32'hFFFF_FC00, 32'h0, "conf_clr");
        wr(32'hFFFF_FC20, 32'hDEAD_BEEF);
        chk("out0_write", {32'h0, out_data[31:0]}, 64'hDEAD_BEEF);
        chk("strobe_pulse", {62'h0, out_strobe}, 64'h1);
        cyc();
        chk("strobe_drop", {62'h0, out_strobe}, 64'h0);
        rd(32'hFFFF_FC20, 32'hDEAD_BEEF, "out0_readback");
        wr(32'hFFFF_FC28, 32'h1234_5678);
        chk("out2_ignored", out_data, {32'h0, 32'hDEAD_BEEF});
        chk("out2_no_strobe", {62'h0, out_strobe}, 64'h0);
        repeat (4000) begin
            if ($urandom_range(499) == 0) begin
                rstn = 0;
                @(posedge clk); #1 rstn = 1;
            end
            case ($urandom_range(2))
                0: ;
                1: io_read = 1;
                default: io_write = 1;
            endcase
            addr = ($urandom_range(15) == 0 ? 32'hFFFF_FD00 : 32'hFFFF_FC00) | {24'h0, offs[$urandom_range(11)]};
            wdata = $urandom;
            key_valid = $urandom_range(2) == 0;
            key_code = 4'($urandom);
            if ($urandom_range(7) == 0) conf_btn = ~conf_btn;
            if ($urandom_range(31) == 0) in_data = $urandom;
            cyc();
        end
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
